grid_clb_param: RTL and testbench
=================================

Name: grid_clb_param

Overview:
- Parametrised next-generation CLB tile: N_BLE basic logic elements, each a K-input LUT plus an optional flip-flop, fed from N_IN tile pins or BLE feedback through a per-input selector.
- Also contains its own configuration-chain segment (ccff_head to ccff_tail), a bit counter and a config-done guard.
- Sits in the fabric grid in place of the fixed clb tile, daisy-chained with neighbouring tiles' ccff chains.
- Configuration and user logic share one clock.

Parameters:
- K, 4, LUT inputs per BLE (2..6)
- N_BLE, 4, BLEs per tile (1..8)
- N_IN, 10, tile input pins
- SEL_W, $clog2(N_IN+N_BLE), derived width of one input-select field
- BLE_BITS, 2**K+1+K*SEL_W, derived config bits per BLE (33 at defaults)
- CFG_BITS, N_BLE*BLE_BITS, derived total config bits (132 at defaults)

Ports:
- clk  input  1  single clock for configuration shift and user logic
- reset  input  1  asynchronous, active-low reset
- prog_en  input  1  1 = configuration mode, shift one bit per clk
- ccff_head  input  1  serial configuration data in
- clb_I  input  N_IN  tile input pins
- ccff_tail  output  1  serial configuration data out (registered)
- clb_O  output  N_BLE  BLE outputs
- cfg_done  output  1  1 = a complete CFG_BITS-bit load has finished since the last restart

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - config register cfg[CFG_BITS-1:0]
  - bit counter cnt (width $clog2(CFG_BITS+1))
  - all BLE flops q[b]
  - prog_en_d (registered prog_en)
  - cfg_done
  - Result: ccff_tail=0, clb_O=0, cfg_done=0.
- Shift (prog_en=1, each clk): cfg <= {ccff_head, cfg[CFG_BITS-1:1]}; ccff_tail = cfg[0]. The first bit shifted in lands at cfg[0] after CFG_BITS shifts.
- Counter:
  - Restart on prog_en=1 && prog_en_d=0: cnt <= 1, cfg_done <= 0.
  - Otherwise, while prog_en=1: cnt increments, saturating at CFG_BITS.
  - cfg_done <= 1 on the clk edge where cnt becomes CFG_BITS; it then holds until the next restart or reset.
  - Extra shifts beyond CFG_BITS are legal: the chain keeps shifting and the data passes through to ccff_tail.
- BLE b config layout, base = b*BLE_BITS:
  - cfg[base +: 2**K] = truth table; bit index = LUT address.
  - cfg[base+2**K] = ff_use.
  - Field k at cfg[base+2**K+1+k*SEL_W +: SEL_W] = source of LUT input k.
- Select decode:
  - s < N_IN: clb_I[s]
  - N_IN <= s < N_IN+N_BLE: q[s-N_IN] (feedback is always the registered q, so there are no combinational loops)
  - s >= N_IN+N_BLE: constant 0
- LUT: lut[b] = truth[addr], where addr = {in[K-1],...,in[0]}.
- BLE flop:
  - q[b] <= lut[b] when active = !prog_en && cfg_done; otherwise q[b] holds.
  - q[b] is cleared only by reset.
- Output: clb_O[b] = active ? (ff_use ? q[b] : lut[b]) : 0. Outputs are forced to 0 during programming and after a partial load.
- Timing: LUT path is combinational, 0 cycles; FF path has 1 cycle latency from clb_I.
- Partial load: prog_en dropped before cnt reaches CFG_BITS leaves cfg_done=0; outputs stay 0 and flops stay frozen.
- Reprogramming: prog_en reasserted after a full load restarts the count; outputs go to 0 in the same cycle (combinational on prog_en).
- Reset asserted mid-load: everything clears immediately; a new load must restart from bit 0.

Optional Feature:
- Macro: GRID_CLB_OUT_REG_EN.
- Defined:
  - clb_O is taken from an extra output register, reset to 0 and loaded every clk with the masked value above.
  - Adds +1 cycle to both the LUT and FF paths.
  - Output is 0 on the first clk after prog_en rises.
- Undefined: clb_O is combinational as described above.

Test Plan:
- Reset, then shift 132 zeros with prog_en=1 -> cfg_done rises exactly on the 132nd edge; clb_O=0; ccff_tail=0 throughout.
- Load BLE0 as a 4-input AND: truth=16'h8000, ff_use=0, selects 0,1,2,3; all other BLEs 0. Then drop prog_en and drive clb_I=10'h00F -> clb_O[0]=1 in the same cycle; clb_I=10'h007 -> clb_O[0]=0.
- Same load with ff_use=1 -> clb_O[0] goes to 1 one clk after clb_I=10'h00F; goes to 0 for any input during prog_en=1.
- Load BLE1 as an inverter (truth=16'h5555) with input 0 select=11, i.e. its own q -> clb_O[1] toggles 1,0,1,0 on successive clks after configuration.
- Load only 100 bits, then drop prog_en -> cfg_done=0, clb_O=4'h0, q unchanged. Reassert prog_en and shift 132 bits -> cfg_done=1.
- Shift a 264-bit pattern -> ccff_tail reproduces the first 132 bits, delayed 132 clks. Assert reset mid-shift -> cfg, cnt and cfg_done go to 0 asynchronously, without waiting for clk.

Source files
------------

// File: rtl/grid_clb_param.sv
// grid_clb_param: parametrised CLB tile with its own configuration-chain segment.
//
// Holds N_BLE basic logic elements. Each one is a K-input LUT with an optional output
// flop. Every LUT input has a selector that picks a tile pin, the registered output of
// a BLE, or constant 0. The configuration bits shift serially from ccff_head to
// ccff_tail. A bit counter raises cfg_done once a full CFG_BITS-bit load has finished.
// The user logic runs only when prog_en=0 and cfg_done=1. Otherwise the outputs are 0
// and the BLE flops hold their value.
//
// Ports:
//   clk        single clock for configuration shift and user logic
//   reset      asynchronous active-low reset
//   prog_en    1 = configuration mode, one bit shifted per clk
//   ccff_head  serial configuration data in
//   clb_I      tile input pins [N_IN-1:0]
//   ccff_tail  serial configuration data out, taken from cfg[0]
//   clb_O      BLE outputs [N_BLE-1:0]
//   cfg_done   a complete load has finished since the last restart
//
// Optional feature: define GRID_CLB_OUT_REG_EN to register clb_O. This adds one cycle
// of latency to both the LUT path and the FF path.
module grid_clb_param #(
  parameter int unsigned K     = 4,
  parameter int unsigned N_BLE = 4,
  parameter int unsigned N_IN  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_en,
  input  logic             ccff_head,
  input  logic [N_IN-1:0]  clb_I,
  output logic             ccff_tail,
  output logic [N_BLE-1:0] clb_O,
  output logic             cfg_done
);

  localparam int unsigned SEL_W    = $clog2(N_IN + N_BLE);
  localparam int unsigned LUT_SIZE = 2 ** K;
  localparam int unsigned BLE_BITS = LUT_SIZE + 1 + K * SEL_W;
  localparam int unsigned CFG_BITS = N_BLE * BLE_BITS;
  localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_done_q, cfg_done_d;
  logic                prog_en_q;
  logic [N_BLE-1:0]    ble_q, ble_d;

  logic [N_BLE-1:0]    lut;
  logic [N_BLE-1:0]    ff_use;
  logic [N_BLE-1:0]    out_val;
  logic                active;

  // Return the value selected by one select field. Codes past the last BLE give 0.
  function automatic logic sel_src(input logic [SEL_W-1:0] s,
                                   input logic [N_IN-1:0]  pins,
                                   input logic [N_BLE-1:0] fb);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (int'(s) == i) r = pins[i];
    end
    for (int j = 0; j < int'(N_BLE); j++) begin
      if (int'(s) == int'(N_IN) + j) r = fb[j];
    end
    return r;
  endfunction

  // Configuration shift register and load counter.
  always_comb begin
    cfg_d      = cfg_q;
    cnt_d      = cnt_q;
    cfg_done_d = cfg_done_q;
    if (prog_en) begin
      cfg_d = {ccff_head, cfg_q[CFG_BITS-1:1]};
      if (!prog_en_q) begin
        // A rising edge on prog_en starts a new load. This edge shifts bit 1.
        cnt_d      = CNT_W'(1);
        cfg_done_d = (CFG_BITS == 1);
      end else if (cnt_q < CNT_W'(CFG_BITS)) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(CFG_BITS)) cfg_done_d = 1'b1;
      end
    end
  end

  // BLE datapath. Feedback comes only from ble_q, so the LUTs cannot form a
  // combinational loop.
  for (genvar b = 0; b < int'(N_BLE); b++) begin : g_ble
    localparam int unsigned Base = b * BLE_BITS;
    logic [LUT_SIZE-1:0] truth;
    logic [K-1:0]        addr;

    assign truth     = cfg_q[Base +: LUT_SIZE];
    assign ff_use[b] = cfg_q[Base + LUT_SIZE];

    for (genvar k = 0; k < int'(K); k++) begin : g_in
      logic [SEL_W-1:0] sel;
      assign sel     = cfg_q[Base + LUT_SIZE + 1 + k * SEL_W +: SEL_W];
      assign addr[k] = sel_src(sel, clb_I, ble_q);
    end

    assign lut[b] = truth[addr];
  end

  assign active = !prog_en && cfg_done_q;

  always_comb begin
    ble_d   = ble_q;
    out_val = '0;
    if (active) begin
      ble_d = lut;
      for (int b = 0; b < int'(N_BLE); b++) begin
        out_val[b] = ff_use[b] ? ble_q[b] : lut[b];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q      <= '0;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      prog_en_q  <= 1'b0;
      ble_q      <= '0;
    end else begin
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done_d;
      prog_en_q  <= prog_en;
      ble_q      <= ble_d;
    end
  end

  assign ccff_tail = cfg_q[0];
  assign cfg_done  = cfg_done_q;

`ifdef GRID_CLB_OUT_REG_EN
  logic [N_BLE-1:0] out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_val;
    end
  end

  assign clb_O = out_q;
`else
  assign clb_O = out_val;
`endif

endmodule

// File: tb/tb_grid_clb_param.sv
// Self-checking bench for grid_clb_param at the default parameters
// (K=4, N_BLE=4, N_IN=10, 33 bits per BLE, 132 bits in total).
// Each check pushes its expected value onto a scoreboard queue when the stimulus is
// driven. The check pops that value and compares it once the DUT output is valid.
module tb_grid_clb_param;

  localparam int CFG_BITS = 132;

  logic         clk;
  logic         rst_n;
  logic         prog_en;
  logic         ccff_head;
  logic [9:0]   clb_I;
  logic         ccff_tail;
  logic [3:0]   clb_O;
  logic         cfg_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  grid_clb_param dut (
    .clk       (clk),
    .reset     (rst_n),
    .prog_en   (prog_en),
    .ccff_head (ccff_head),
    .clb_I     (clb_I),
    .ccff_tail (ccff_tail),
    .clb_O     (clb_O),
    .cfg_done  (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: got %0h required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift the first n bits of c, bit 0 first, then leave configuration mode.
  task automatic load(input logic [CFG_BITS-1:0] c, input int n);
    prog_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      ccff_head = c[i];
      tick();
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  // Build one BLE config word: {sel3, sel2, sel1, sel0, ff_use, truth}.
  function automatic logic [32:0] ble(input logic [15:0] t, input logic ff,
                                      input logic [3:0] s0, input logic [3:0] s1,
                                      input logic [3:0] s2, input logic [3:0] s3);
    return {s3, s2, s1, s0, ff, t};
  endfunction

  logic [CFG_BITS-1:0] and_comb, and_ff, inv_cfg;
  logic [263:0]        pat;
  logic                tail_bad;

  initial begin
    rst_n     = 1'b0;
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    clb_I     = '0;

    and_comb = {33'd0, 33'd0, 33'd0, ble(16'h8000, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3)};
    and_ff   = {33'd0, 33'd0, 33'd0, ble(16'h8000, 1'b1, 4'd0, 4'd1, 4'd2, 4'd3)};
    inv_cfg  = {33'd0, 33'd0, ble(16'h5555, 1'b1, 4'd11, 4'd14, 4'd14, 4'd14), 33'd0};

    // Reset values are checked before any clock edge arrives.
    #1;
    sb_push("rst_tail", 0);  sb_check(32'(ccff_tail));
    sb_push("rst_out", 0);   sb_check(32'(clb_O));
    sb_push("rst_done", 0);  sb_check(32'(cfg_done));
    tick();
    tick();
    rst_n = 1'b1;

    // Shift 132 zeros. cfg_done must rise exactly on edge 132.
    tail_bad = 1'b0;
    prog_en  = 1'b1;
    for (int i = 1; i <= CFG_BITS; i++) begin
      ccff_head = 1'b0;
      tick();
      if (ccff_tail !== 1'b0 || clb_O !== 4'h0) tail_bad = 1'b1;
      if (i == CFG_BITS - 1) begin
        sb_push("done_at_131", 0); sb_check(32'(cfg_done));
      end
    end
    sb_push("done_at_132", 1);     sb_check(32'(cfg_done));
    sb_push("zero_shift_quiet", 0); sb_check(32'(tail_bad));
    prog_en = 1'b0;

    // BLE0 is a combinational 4-input AND.
    load(and_comb, CFG_BITS);
    clb_I = 10'h00F; sb_push("and_comb_f", 4'h1); #1 sb_check(32'(clb_O));
    clb_I = 10'h007; sb_push("and_comb_7", 4'h0); #1 sb_check(32'(clb_O));
    clb_I = 10'h3F0; sb_push("and_comb_3f0", 4'h0); #1 sb_check(32'(clb_O));
    tick();  // q[0] now holds 0

    // The same AND through the flop: one cycle of latency.
    clb_I = 10'h000;
    load(and_ff, CFG_BITS);
    sb_push("and_ff_idle", 4'h0); #1 sb_check(32'(clb_O));
    clb_I = 10'h00F;
    sb_push("and_ff_same_cycle", 4'h0); #1 sb_check(32'(clb_O));
    tick();
    sb_push("and_ff_next_cycle", 4'h1); sb_check(32'(clb_O));
    prog_en = 1'b1;
    sb_push("prog_forces_zero", 4'h0); #1 sb_check(32'(clb_O));
    tick();
    clb_I = 10'h3FF;
    sb_push("prog_zero_3ff", 4'h0); #1 sb_check(32'(clb_O));
    prog_en = 1'b0;
    sb_push("restart_clears_done", 0); #1 sb_check(32'(cfg_done));
    sb_push("restart_out_zero", 4'h0); sb_check(32'(clb_O));

    // BLE1 is an inverter of its own q, so it toggles every clk.
    clb_I = 10'h000;
    load(inv_cfg, CFG_BITS);
    sb_push("inv_start", 4'h0); #1 sb_check(32'(clb_O));
    tick(); sb_push("inv_t1", 4'h2); sb_check(32'(clb_O));
    tick(); sb_push("inv_t2", 4'h0); sb_check(32'(clb_O));
    tick(); sb_push("inv_t3", 4'h2); sb_check(32'(clb_O));

    // Partial load: outputs stay 0 and q[1] (now 1) stays frozen.
    load(and_comb, 100);
    clb_I = 10'h00F;
    sb_push("partial_done", 0);   #1 sb_check(32'(cfg_done));
    sb_push("partial_out", 4'h0); sb_check(32'(clb_O));
    tick();
    clb_I = 10'h3FF;
    sb_push("partial_out_2", 4'h0); #1 sb_check(32'(clb_O));
    tick();
    clb_I = 10'h000;
    load(inv_cfg, CFG_BITS);
    sb_push("reload_done", 1);  #1 sb_check(32'(cfg_done));
    sb_push("q_held", 4'h2);    sb_check(32'(clb_O));
    tick(); sb_push("q_toggles", 4'h0); sb_check(32'(clb_O));

    // 264-bit pattern: ccff_tail replays the first 132 bits, delayed by 132 clks.
    for (int i = 0; i < 264; i++) pat[i] = 1'($urandom_range(0, 1));
    pat[132] = 1'b1;
    prog_en = 1'b1;
    for (int i = 0; i < 264; i++) begin
      ccff_head = pat[i];
      sb_push($sformatf("tail_bit%0d", i), 32'(pat[i]));
      tick();
      if (i >= CFG_BITS - 1) sb_check(32'(ccff_tail));
    end
    sb.delete();
    sb_push("pat_done", 1); sb_check(32'(cfg_done));

    // Reset in the middle of the cycle must clear state without waiting for a clk edge.
    #2 rst_n = 1'b0;
    #1;
    sb_push("async_tail", 0); sb_check(32'(ccff_tail));
    sb_push("async_done", 0); sb_check(32'(cfg_done));
    sb_push("async_out", 0);  sb_check(32'(clb_O));
    #1 rst_n = 1'b1;

    // After reset the counter restarts from bit 1 and cfg holds only zeros.
    tail_bad = 1'b0;
    for (int i = 1; i <= CFG_BITS; i++) begin
      ccff_head = 1'b0;
      tick();
      if (ccff_tail !== 1'b0) tail_bad = 1'b1;
      if (i == CFG_BITS - 1) begin
        sb_push("post_rst_131", 0); sb_check(32'(cfg_done));
      end
    end
    sb_push("post_rst_132", 1);    sb_check(32'(cfg_done));
    sb_push("post_rst_cleared", 0); sb_check(32'(tail_bad));
    prog_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
